// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I(M) controller: opcodes, ALU ops,
// datapath select codes, FSM states and decoded instruction classes.
package rv_ctrl_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;
  localparam logic [1:0] WB_MDU = 2'b11;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MDU_WAIT, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_ALUI, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_MDU
  } iclass_t;

  // funct3 to ALU op for the register/immediate arithmetic groups
  function automatic logic [4:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv_decoder.sv
// Combinational instruction decode: class, illegal flag, ALU op and immediate format.
module rv_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [31:0] inst,
  output iclass_t     iclass,
  output logic        illegal,
  output logic [4:0]  alu_op,
  output logic [2:0]  imm_src
);
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign unused_bits = ^{inst[24:15], inst[11:7]};

  always_comb begin
    iclass  = C_ALU;
    illegal = 1'b0;
    alu_op  = ALU_ADD;
    imm_src = IMM_I;
    case (opcode)
      OP_REG: begin
        alu_op = f3_op(funct3);
        if (funct7 == 7'b0000001) begin
          iclass  = C_MDU;
          alu_op  = ALU_ADD;
          illegal = (ENABLE_M == 0);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      alu_op  = ALU_SUB;
          else if (funct3 == 3'b101) alu_op  = ALU_SRA;
          else                       illegal = 1'b1;
        end else if (funct7 != 7'b0000000) begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        iclass = C_ALUI;
        alu_op = f3_op(funct3);
        // funct7 sits in the immediate field but is meaningful for shifts
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)      alu_op  = ALU_SRA;
          else if (funct7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OP_LUI: begin
        iclass  = C_LUI;
        alu_op  = ALU_LUI;
        imm_src = IMM_U;
      end
      OP_AUIPC: begin
        iclass  = C_AUIPC;
        imm_src = IMM_U;
      end
      OP_LOAD: begin
        iclass  = C_LOAD;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        iclass  = C_STORE;
        imm_src = IMM_S;
        illegal = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        iclass  = C_BRANCH;
        imm_src = IMM_B;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        iclass  = C_JAL;
        imm_src = IMM_J;
      end
      OP_JALR: begin
        iclass  = C_JALR;
        illegal = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I(M) control FSM: fetch/decode/execute/memory/writeback with
// memory and MDU handshakes, a wait watchdog and a sticky trap state.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_M     = 1,
  parameter int WAIT_TIMEOUT = 16,
  parameter int TO_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        mdu_done,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mdu_start,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        pc_src,
  output logic        pc_lsb_clr,
  output logic        reg_wr,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  wb_sel,
  output logic [2:0]  imm_src,
  output logic [4:0]  alu_op,
  output logic [2:0]  funct3,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        retire,
  output logic [2:0]  state_o
);
  state_t          state, next;
  iclass_t         cls_q, dec_cls;
  logic            dec_ill;
  logic [4:0]      dec_alu;
  logic [2:0]      dec_imm;
  logic [1:0]      cause_q, cause_d;
  logic [TO_W-1:0] wd;
  logic            waiting, expired;

  rv_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
    .inst    (inst),
    .iclass  (dec_cls),
    .illegal (dec_ill),
    .alu_op  (dec_alu),
    .imm_src (dec_imm)
  );

  assign funct3  = inst[14:12];
  assign state_o = state;
  assign waiting = state inside {S_FETCH, S_MEM, S_MDU_WAIT};
  // wd holds cycles already spent, so the limit is hit on the WAIT_TIMEOUT-th cycle
  assign expired = (WAIT_TIMEOUT != 0) && waiting && (wd == TO_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls_q   <= C_ALU;
      cause_q <= TC_NONE;
      wd      <= '0;
    end else begin
      state   <= next;
      cause_q <= cause_d;
      wd      <= (next != state || !waiting) ? '0 : wd + 1'b1;
      if (state == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    next    = state;
    cause_d = cause_q;
    case (state)
      S_FETCH: begin
        if (imem_ack)     next = S_DECODE;
        else if (expired) begin next = S_TRAP; cause_d = TC_TIMEOUT; end
      end
      S_DECODE: begin
        if (dec_ill) begin next = S_TRAP; cause_d = TC_ILLEGAL; end
        else         next = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: next = S_MEM;
          C_MDU:           next = S_MDU_WAIT;
          C_BRANCH:        next = S_FETCH;
          default:         next = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)     next = (cls_q == C_STORE) ? S_FETCH : S_WB;
        else if (expired) begin next = S_TRAP; cause_d = TC_TIMEOUT; end
      end
      S_MDU_WAIT: begin
        if (mdu_done)     next = S_WB;
        else if (expired) begin next = S_TRAP; cause_d = TC_TIMEOUT; end
      end
      S_WB:    next = S_FETCH;
      S_TRAP:  next = S_TRAP;
      default: next = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    mdu_start  = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 1'b0;
    pc_lsb_clr = 1'b0;
    reg_wr     = 1'b0;
    sel_A      = 1'b0;
    sel_B      = 1'b0;
    wb_sel     = WB_PC4;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    trap       = 1'b0;
    trap_cause = TC_NONE;
    retire     = 1'b0;
    // reset masks every strobe immediately, even while the state still shows a wait
    if (!rst) begin
      if (state inside {S_EXEC, S_MEM, S_MDU_WAIT, S_WB}) begin
        sel_A   = !(cls_q inside {C_LUI, C_AUIPC, C_BRANCH, C_JAL});
        sel_B   = !(cls_q inside {C_ALU, C_MDU});
        imm_src = dec_imm;
        alu_op  = dec_alu;
      end
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr    = imem_ack;
        end
        S_EXEC: begin
          mdu_start = (cls_q == C_MDU);
          if (cls_q == C_BRANCH) begin
            pc_wr  = 1'b1;
            pc_src = br_taken;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          if (cls_q == C_STORE && dmem_ack) begin
            pc_wr  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          reg_wr     = 1'b1;
          pc_wr      = 1'b1;
          retire     = 1'b1;
          pc_src     = (cls_q inside {C_JAL, C_JALR});
          pc_lsb_clr = (cls_q == C_JALR);
          case (cls_q)
            C_LOAD:        wb_sel = WB_MEM;
            C_MDU:         wb_sel = WB_MDU;
            C_JAL, C_JALR: wb_sel = WB_PC4;
            default:       wb_sel = WB_ALU;
          endcase
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed test-plan steps plus random instructions,
// each cycle compared against an expected output bundle built from instruction fields.
module tb_multicycle_controller;
  import rv_ctrl_pkg::*;

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_LD = 4, K_ST = 5,
                 K_BR = 6, K_JAL = 7, K_JALR = 8, K_MUL = 9;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, mdu_start, ir_wr;
    logic       pc_wr, pc_src, pc_lsb_clr, reg_wr, sel_a, sel_b;
    logic [1:0] wb_sel;
    logic [2:0] imm_src;
    logic [4:0] alu_op;
    logic       trap;
    logic [1:0] trap_cause;
    logic       retire;
    logic [2:0] state;
  } obs_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] kind;
    logic       sa, sb;
    logic [2:0] imm;
    logic [4:0] alu;
  } ref_t;

  logic clk, rst, rst2, br_taken, imem_ack, dmem_ack, mdu_done;
  logic [31:0] inst;
  logic imem_req, dmem_req, dmem_we, mdu_start, ir_wr, pc_wr, pc_src, pc_lsb_clr, reg_wr;
  logic sel_A, sel_B, trap, retire;
  logic [1:0] wb_sel, trap_cause;
  logic [2:0] imm_src, funct3, state_o;
  logic [4:0] alu_op;
  logic m0_imem_req, m0_dmem_req, m0_dmem_we, m0_mdu_start, m0_ir_wr, m0_pc_wr, m0_pc_src;
  logic m0_pc_lsb_clr, m0_reg_wr, m0_sel_A, m0_sel_B, m0_trap, m0_retire;
  logic [1:0] m0_wb_sel, m0_trap_cause;
  logic [2:0] m0_imm_src, unused_m0_funct3, m0_state_o;
  logic [4:0] m0_alu_op;
  obs_t act, act2;
  int checks = 0, failures = 0;

  multicycle_controller #(.ENABLE_M(1), .WAIT_TIMEOUT(16), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .inst(inst), .br_taken(br_taken), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .mdu_done(mdu_done), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .mdu_start(mdu_start), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .pc_lsb_clr(pc_lsb_clr), .reg_wr(reg_wr), .sel_A(sel_A), .sel_B(sel_B), .wb_sel(wb_sel),
    .imm_src(imm_src), .alu_op(alu_op), .funct3(funct3), .trap(trap), .trap_cause(trap_cause),
    .retire(retire), .state_o(state_o));

  // No M extension and a short watchdog
  multicycle_controller #(.ENABLE_M(0), .WAIT_TIMEOUT(4), .TO_W(8)) dut_m0 (
    .clk(clk), .rst(rst2), .inst(inst), .br_taken(br_taken), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .mdu_done(mdu_done), .imem_req(m0_imem_req), .dmem_req(m0_dmem_req),
    .dmem_we(m0_dmem_we), .mdu_start(m0_mdu_start), .ir_wr(m0_ir_wr), .pc_wr(m0_pc_wr),
    .pc_src(m0_pc_src), .pc_lsb_clr(m0_pc_lsb_clr), .reg_wr(m0_reg_wr), .sel_A(m0_sel_A),
    .sel_B(m0_sel_B), .wb_sel(m0_wb_sel), .imm_src(m0_imm_src), .alu_op(m0_alu_op),
    .funct3(unused_m0_funct3), .trap(m0_trap), .trap_cause(m0_trap_cause),
    .retire(m0_retire), .state_o(m0_state_o));

  assign act  = {imem_req, dmem_req, dmem_we, mdu_start, ir_wr, pc_wr, pc_src, pc_lsb_clr,
                 reg_wr, sel_A, sel_B, wb_sel, imm_src, alu_op, trap, trap_cause, retire, state_o};
  assign act2 = {m0_imem_req, m0_dmem_req, m0_dmem_we, m0_mdu_start, m0_ir_wr, m0_pc_wr,
                 m0_pc_src, m0_pc_lsb_clr, m0_reg_wr, m0_sel_A, m0_sel_B, m0_wb_sel, m0_imm_src,
                 m0_alu_op, m0_trap, m0_trap_cause, m0_retire, m0_state_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  function automatic ref_t ref_dec(input logic [31:0] x, input bit m_on);
    ref_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] tab [8];
    tab = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    op = x[6:0]; f7 = x[31:25]; f3 = x[14:12];
    r = '{legal: 1'b1, kind: 4'(K_R), sa: 1'b1, sb: 1'b1, imm: 3'd0, alu: 5'd0};
    case (op)
      7'h33: begin
        r.sb = 1'b0; r.alu = tab[f3];
        if (f7 == 7'h01) begin r.kind = 4'(K_MUL); r.alu = 5'd0; r.legal = m_on; end
        else if (f7 == 7'h20) begin
          if (f3 == 3'd0)      r.alu = 5'd1;
          else if (f3 == 3'd5) r.alu = 5'd7;
          else                 r.legal = 1'b0;
        end else if (f7 != 7'h00) r.legal = 1'b0;
      end
      7'h13: begin
        r.kind = 4'(K_I); r.alu = tab[f3];
        if (f3 == 3'd1) r.legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) r.alu = 5'd7;
          else             r.legal = (f7 == 7'h00);
        end
      end
      7'h37: begin r.kind = 4'(K_LUI); r.sa = 1'b0; r.imm = 3'd4; r.alu = 5'd10; end
      7'h17: begin r.kind = 4'(K_AUIPC); r.sa = 1'b0; r.imm = 3'd4; end
      7'h03: begin r.kind = 4'(K_LD); r.legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      7'h23: begin r.kind = 4'(K_ST); r.imm = 3'd1; r.legal = (f3 <= 3'd2); end
      7'h63: begin r.kind = 4'(K_BR); r.sa = 1'b0; r.imm = 3'd2; r.legal = !(f3 == 3'd2 || f3 == 3'd3); end
      7'h6f: begin r.kind = 4'(K_JAL); r.sa = 1'b0; r.imm = 3'd3; end
      7'h67: begin r.kind = 4'(K_JALR); r.legal = (f3 == 3'd0); end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic obs_t ob(input state_t s);
    obs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic obs_t ctl(input state_t s, input ref_t r);
    obs_t o;
    o = ob(s);
    o.sel_a = r.sa; o.sel_b = r.sb; o.imm_src = r.imm; o.alu_op = r.alu;
    return o;
  endfunction

  task automatic cyc(input string tag, input obs_t e, input bit d2 = 1'b0);
    obs_t a;
    #1;
    a = d2 ? act2 : act;
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, a, e);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic do_reset();
    obs_t e;
    @(negedge clk); rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    #1 chk_val("reset_strobes", 32'(act[27:3]), 32'd0);
    @(negedge clk); e = ob(S_FETCH); cyc("reset_state", e);
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] x, input int fd, input int md,
                           input logic br, input int abort_at);
    ref_t r;
    obs_t e;
    r = ref_dec(x, 1'b1);
    for (int i = 0; i <= fd; i++) begin
      @(negedge clk);
      inst = $urandom; imem_ack = (i == fd);
      dmem_ack = 1'($urandom); mdu_done = 1'($urandom); br_taken = 1'($urandom);
      e = ob(S_FETCH); e.imem_req = 1'b1; e.ir_wr = (i == fd);
      cyc("fetch", e);
    end
    @(negedge clk); inst = x; imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    e = ob(S_DECODE); cyc("decode", e);
    if (!r.legal) begin
      @(negedge clk); e = ob(S_TRAP); e.trap = 1'b1; e.trap_cause = 2'b01;
      cyc("trap_illegal", e);
      return;
    end
    @(negedge clk); br_taken = br;
    e = ctl(S_EXEC, r);
    if (r.kind == K_BR) begin
      e.pc_wr = 1'b1; e.pc_src = br; e.retire = 1'b1;
      cyc("exec_branch", e);
      return;
    end
    e.mdu_start = (r.kind == K_MUL);
    cyc("exec", e);
    chk_val("funct3", 32'(funct3), 32'(x[14:12]));
    if (r.kind == K_LD || r.kind == K_ST) begin
      for (int i = 0; i <= md; i++) begin
        @(negedge clk);
        if (i == abort_at) begin
          rst = 1'b1; dmem_ack = 1'b0;
          #1 chk_val("abort_strobes", 32'(act[27:3]), 32'd0);
          @(negedge clk); e = ob(S_FETCH); cyc("abort_fetch", e);
          rst = 1'b0;
          return;
        end
        dmem_ack = (i == md);
        e = ctl(S_MEM, r); e.dmem_req = 1'b1; e.dmem_we = (r.kind == K_ST);
        if (r.kind == K_ST && i == md) begin e.pc_wr = 1'b1; e.retire = 1'b1; end
        cyc("mem", e);
      end
      if (r.kind == K_ST) return;
    end
    if (r.kind == K_MUL) begin
      for (int i = 0; i <= md; i++) begin
        @(negedge clk); mdu_done = (i == md);
        e = ctl(S_MDU_WAIT, r); cyc("mdu_wait", e);
      end
    end
    @(negedge clk); dmem_ack = 1'b0; mdu_done = 1'b0;
    e = ctl(S_WB, r); e.reg_wr = 1'b1; e.pc_wr = 1'b1; e.retire = 1'b1;
    e.pc_src = (r.kind == K_JAL || r.kind == K_JALR);
    e.pc_lsb_clr = (r.kind == K_JALR);
    e.wb_sel = (r.kind == K_LD) ? 2'b10 : (r.kind == K_MUL) ? 2'b11 :
               (r.kind == K_JAL || r.kind == K_JALR) ? 2'b00 : 2'b01;
    cyc("wb", e);
  endtask

  initial begin
    obs_t e;
    ref_t r;
    logic [31:0] x;
    logic [6:0] op_tab [9];
    int k;
    op_tab = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
    rst = 1'b1; rst2 = 1'b1; inst = '0; br_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    repeat (2) @(negedge clk);
    e = ob(S_FETCH); cyc("reset", e); cyc("reset_m0", e, 1'b1);
    rst = 1'b0;

    run_instr(32'h002081B3, 2, 0, 1'b0, -1);  // ADD, ack on 3rd fetch cycle
    run_instr(32'h0080A283, 0, 2, 1'b0, -1);  // LW, dmem_ack in 3rd MEM cycle
    run_instr(32'h00208463, 0, 0, 1'b1, -1);  // BEQ taken
    run_instr(32'h00208463, 1, 0, 1'b0, -1);  // BEQ not taken
    run_instr(32'h022081B3, 0, 4, 1'b0, -1);  // MUL, done in 5th wait cycle
    run_instr(32'h0020A223, 0, 1, 1'b0, -1);  // SW
    run_instr(32'h000100E7, 0, 0, 1'b0, -1);  // JALR
    run_instr(32'h010000EF, 0, 0, 1'b0, -1);  // JAL
    run_instr(32'h123452B7, 0, 0, 1'b0, -1);  // LUI
    run_instr(32'h00001297, 0, 0, 1'b0, -1);  // AUIPC

    run_instr(32'h402091B3, 0, 0, 1'b0, -1);  // SLL with funct7=0100000
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); imem_ack = 1'($urandom); dmem_ack = 1'($urandom); mdu_done = 1'($urandom);
      e = ob(S_TRAP); e.trap = 1'b1; e.trap_cause = 2'b01; cyc("trap_sticky", e);
    end
    do_reset();
    run_instr(32'h0080A283, 0, 5, 1'b0, 1);   // reset during the MEM wait
    run_instr(32'h002081B3, 0, 0, 1'b0, -1);

    // Watchdog and ENABLE_M=0 on the second instance
    @(negedge clk); rst = 1'b1; rst2 = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    inst = 32'h022081B3;
    @(negedge clk); rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      e = ob(S_FETCH); e.imem_req = 1'b1; cyc("m0_timeout_wait", e, 1'b1);
    end
    @(negedge clk); e = ob(S_TRAP); e.trap = 1'b1; e.trap_cause = 2'b10;
    cyc("m0_timeout_trap", e, 1'b1);
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk); rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      imem_ack = (i == 3);
      e = ob(S_FETCH); e.imem_req = 1'b1; e.ir_wr = (i == 3); cyc("m0_ack_at_limit", e, 1'b1);
    end
    @(negedge clk); imem_ack = 1'b0; e = ob(S_DECODE); cyc("m0_decode_mul", e, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); e = ob(S_TRAP); e.trap = 1'b1; e.trap_cause = 2'b01;
      cyc("m0_mul_illegal", e, 1'b1);
    end
    @(negedge clk); rst2 = 1'b1;
    do_reset();

    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) x[6:0] = op_tab[k];
      case ($urandom_range(0, 3))
        0: x[31:25] = 7'h00;
        1: x[31:25] = 7'h20;
        2: x[31:25] = 7'h01;
        default: ;
      endcase
      r = ref_dec(x, 1'b1);
      run_instr(x, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
      if (!r.legal) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM-based control unit for the multi-cycle RV32I(M) core. It replaces purely combinational decode with a fetch/decode/execute/memory/writeback sequence.
- Adds valid/ack handshakes to instruction memory, data memory and an optional multiply/divide unit (MDU), a wait-timeout watchdog, illegal-instruction detection, a sticky trap state and a retire strobe.
- Sits between the instruction register (IR), the datapath muxes, the ALU, the memories and the MDU.

Parameters:
- ENABLE_M, 1, 1 = decode M-extension (opcode 0110011, funct7 0000001); 0 = such instructions are illegal.
- WAIT_TIMEOUT, 16, maximum cycles spent in any wait state before a timeout trap; 0 = watchdog disabled.
- TO_W, 8, width of the watchdog counter; requires WAIT_TIMEOUT < 2**TO_W.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- inst in 32: IR contents, stable from DECODE until the instruction retires.
- br_taken in 1: branch comparator result.
- imem_ack in 1, dmem_ack in 1, mdu_done in 1: completion handshakes.
- imem_req out 1, dmem_req out 1, dmem_we out 1, mdu_start out 1: memory and MDU requests.
- ir_wr out 1, pc_wr out 1, pc_src out 1, pc_lsb_clr out 1, reg_wr out 1: register and PC write controls.
- sel_A out 1: 1 = rs1, 0 = PC. sel_B out 1: 1 = immediate, 0 = rs2.
- wb_sel out 2: 00 PC+4, 01 ALU, 10 memory, 11 MDU.
- imm_src out 3: I=000, S=001, B=010, J=011, U=100.
- alu_op out 5: ADD..LUI codes 0..10.
- funct3 out 3: inst[14:12], passthrough.
- trap out 1, trap_cause out 2: 01 illegal, 10 timeout.
- retire out 1: one-cycle pulse when an instruction completes.
- state_o out 3: current state, for debug.

Behaviour:
- Reset: while rst is high, every strobe, trap and trap_cause is 0 and the state loads FETCH. The watchdog clears. Reset asserted mid-operation aborts immediately; no request is held.
- States: FETCH, DECODE, EXEC, MEM, MDU_WAIT, WB, TRAP. Control outputs are combinational from the state and inst.
- Don't-care values: every non-relevant output drives 0; no X values are driven.
- FETCH:
  - imem_req=1 is held until imem_ack.
  - In the ack cycle, ir_wr=1 and the next state is DECODE.
- DECODE: one cycle.
  - The instruction class is registered.
  - An illegal encoding goes to TRAP with cause 01; otherwise the next state is EXEC.
- Illegal encodings:
  - Unknown opcode.
  - R-type funct7 not 0000000 or 0100000, and 0100000 used with any funct3 other than 000 or 101.
  - M-extension instruction when ENABLE_M=0.
  - Shift-immediate with bad funct7.
  - Branch funct3 010 or 011.
  - Load funct3 011, 110 or 111.
  - Store funct3 above 010.
  - JALR funct3 not 000.
- EXEC:
  - ALU, LUI and AUIPC go to WB.
  - Load and store go to MEM.
  - JAL and JALR go to WB.
  - M-extension: mdu_start pulses for exactly 1 cycle, then MDU_WAIT.
  - Branch: pc_wr=1; pc_src equals br_taken (1 = ALU target); retire=1; next state FETCH. reg_wr stays 0.
- MEM:
  - dmem_req=1 is held until dmem_ack; dmem_we=1 only for stores.
  - Store: on ack, pc_wr=1, pc_src=0, retire=1, next state FETCH.
  - Load: on ack, next state WB.
- MDU_WAIT: on mdu_done, next state WB.
- WB:
  - reg_wr=1 for exactly one cycle, with wb_sel per class.
  - pc_wr=1; retire=1; next state FETCH.
  - pc_src=1 for JAL and JALR; pc_lsb_clr=1 for JALR only.
- ALU controls: sel_A, sel_B, imm_src and alu_op stay constant from EXEC through WB of one instruction.
  - Branch and JAL: sel_A=0, sel_B=1, alu_op=ADD.
  - JALR: sel_A=1, imm_src=I.
  - AUIPC: sel_A=0.
- Watchdog:
  - Counts cycles in FETCH, MEM and MDU_WAIT and clears on every state change.
  - When the count reaches WAIT_TIMEOUT with no ack/done, the next state is TRAP with cause 10.
  - An ack arriving in the same cycle as the limit wins.
- TRAP: sticky. trap=1, trap_cause is held and all other strobes are 0. Only rst exits it.
- Retire rule: no instruction asserts reg_wr or pc_wr more than once.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - alu_op codes, ADD=0 through LUI=10;
  - imm_src, wb_sel and trap_cause encodings;
  - the state enum and the instruction-class enum.
- One natural sub-module, rv_decoder: combinational inst to class, illegal flag, alu_op and imm_src.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with imem_ack on the 3rd FETCH cycle:
  - Required sequence: 3 FETCH cycles, DECODE, EXEC, WB; 6 cycles in total.
  - EXEC: alu_op=00000, sel_A=1, sel_B=0.
  - WB: reg_wr=1, wb_sel=01, pc_wr=1, pc_src=0, retire=1.
- LW x5,8(x1) (0x0080A283) with dmem_ack 3 cycles after MEM entry:
  - dmem_req held 3 cycles with dmem_we=0.
  - WB wb_sel=10, imm_src=000.
- BEQ x1,x2,+8 (0x00208463):
  - br_taken=1 gives EXEC pc_wr=1, pc_src=1, imm_src=010; reg_wr is never 1.
  - Repeat with br_taken=0: pc_src=0.
- MUL x3,x1,x2 (0x022081B3) with ENABLE_M=1 and mdu_done 5 cycles later:
  - mdu_start is high for 1 cycle; WB wb_sel=11.
  - With ENABLE_M=0: TRAP with trap_cause=01 and no reg_wr.
- Illegal encoding 0x402091B3 (SLL with funct7=0100000): TRAP, cause 01. Sticky across 10 cycles; rst returns the FSM to FETCH.
- Timeout and reset-abort:
  - WAIT_TIMEOUT=4 with imem_ack held 0: TRAP with cause 10 after 4 FETCH cycles; imem_req drops.
  - rst asserted during a MEM wait: dmem_req=0 on the next cycle; FETCH follows release.
